// File: rtl/column_scheduler_if.sv
// Player-input and playfield-status bundle shared by the input logic, the
// column scheduler and the display renderer.
interface column_scheduler_if #(
    parameter int unsigned NUM_SLOTS = 4
);
    logic                   start;
    logic [7:0]             user_input;
    logic                   user_strobe;
    logic [NUM_SLOTS-1:0]   slot_active;
    logic [5*NUM_SLOTS-1:0] slot_ypos;
    logic [8*NUM_SLOTS-1:0] slot_letter;
    logic [7:0]             score;
    logic [3:0]             level;
    logic                   game_over;
    logic                   hit;
    logic                   miss;
    logic                   fall_tick;

    modport master (
        output start, user_input, user_strobe,
        input  slot_active, slot_ypos, slot_letter, score, level,
               game_over, hit, miss, fall_tick
    );

    modport slave (
        input  start, user_input, user_strobe,
        output slot_active, slot_ypos, slot_letter, score, level,
               game_over, hit, miss, fall_tick
    );
endinterface

// File: rtl/column_scheduler.sv
// Falling-letter game controller: owns the column slots, the fall tick,
// spawning, player matching, scoring and game-over detection.
module column_scheduler #(
    parameter int unsigned NUM_SLOTS       = 4,
    parameter int unsigned BOTTOM_ROW      = 22,
    parameter int unsigned TICK_START      = 50000000,
    parameter int unsigned TICK_MIN        = 5000000,
    parameter int unsigned TICK_STEP       = 2500000,
    parameter int unsigned SPAWN_EVERY     = 4,
    parameter int unsigned SCORE_PER_LEVEL = 8
) (
    input logic               clock,
    input logic               reset_signal,
    column_scheduler_if.slave bus
);
    localparam int unsigned TW = 26;
    localparam int unsigned YW = 5;
    localparam int unsigned LW = 8;
    localparam int unsigned SW = (SPAWN_EVERY > 1) ? $clog2(SPAWN_EVERY) : 1;
    localparam int unsigned IW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_PLAYING = 2'd1;
    localparam logic [1:0] S_OVER    = 2'd2;

    localparam logic [LW-1:0] LFSR_SEED = 8'hA5;
    localparam logic [LW-1:0] LFSR_MASK = 8'hB8;
    localparam logic [TW-1:0] T_START   = TW'(TICK_START);
    localparam logic [TW-1:0] T_MIN     = TW'(TICK_MIN);
    localparam logic [TW-1:0] T_SPAN    = TW'(TICK_START - TICK_MIN);
    localparam logic [YW-1:0] Y_BOTTOM  = YW'(BOTTOM_ROW);

    logic [1:0]                    state_q, state_d;
    logic [LW-1:0]                 lfsr_q, lfsr_d;
    logic [NUM_SLOTS-1:0]          active_q, active_d;
    logic [NUM_SLOTS-1:0][YW-1:0]  ypos_q, ypos_d;
    logic [NUM_SLOTS-1:0][LW-1:0]  letter_q, letter_d;
    logic [7:0]                    score_q, score_d;
    logic [3:0]                    level_q, level_d;
    logic [TW-1:0]                 tick_cnt_q, tick_cnt_d;
    logic [SW-1:0]                 spawn_cnt_q, spawn_cnt_d;
    logic                          game_over_q, game_over_d;
    logic                          hit_q, hit_d;
    logic                          miss_q, miss_d;
    logic                          fall_tick_q, fall_tick_d;

    logic [TW-1:0]                 dec_c, period_c;
    logic                          tick_c, strobe_c, hit_c;
    logic                          win_found_c, free_found_c;
    logic [IW-1:0]                 win_idx_c, free_idx_c;
    logic [YW-1:0]                 win_y_c;
    logic                          bottom_c, spawn_c;
    logic [31:0]                   level_raw_c;

    // Fall period shrinks with level; clamp before subtracting so it never wraps.
    assign dec_c    = TW'(level_q) * TW'(TICK_STEP);
    assign period_c = (dec_c >= T_SPAN) ? T_MIN : (T_START - dec_c);
    // A shorter period after a level-up takes effect without wrapping the counter.
    assign tick_c   = (state_q == S_PLAYING) && (tick_cnt_q >= (period_c - TW'(1)));
    assign strobe_c = (state_q == S_PLAYING) && bus.user_strobe;
    assign hit_c    = strobe_c && win_found_c;

    // Winner is the deepest matching column; strict compare keeps the lowest index on ties.
    always_comb begin
        win_found_c  = 1'b0;
        win_idx_c    = '0;
        win_y_c      = '0;
        free_found_c = 1'b0;
        free_idx_c   = '0;
        for (int i = 0; i < int'(NUM_SLOTS); i++) begin
            if (active_q[i] && (letter_q[i] == bus.user_input) &&
                (!win_found_c || (ypos_q[i] > win_y_c))) begin
                win_found_c = 1'b1;
                win_idx_c   = IW'(i);
                win_y_c     = ypos_q[i];
            end
            if (!active_q[i] && !free_found_c) begin
                free_found_c = 1'b1;
                free_idx_c   = IW'(i);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        lfsr_d      = {1'b0, lfsr_q[LW-1:1]} ^ (lfsr_q[0] ? LFSR_MASK : '0);
        active_d    = active_q;
        ypos_d      = ypos_q;
        letter_d    = letter_q;
        score_d     = score_q;
        level_d     = level_q;
        tick_cnt_d  = tick_cnt_q;
        spawn_cnt_d = spawn_cnt_q;
        game_over_d = game_over_q;
        hit_d       = 1'b0;
        miss_d      = 1'b0;
        fall_tick_d = 1'b0;
        bottom_c    = 1'b0;
        spawn_c     = 1'b0;
        level_raw_c = '0;

        case (state_q)
            S_IDLE, S_OVER: begin
                if (bus.start) begin
                    state_d     = S_PLAYING;
                    active_d    = '0;
                    ypos_d      = '0;
                    letter_d    = '0;
                    score_d     = '0;
                    level_d     = '0;
                    tick_cnt_d  = '0;
                    spawn_cnt_d = '0;
                    game_over_d = 1'b0;
                    active_d[0] = 1'b1;
                    letter_d[0] = lfsr_q;
                end
            end
            S_PLAYING: begin
                tick_cnt_d = tick_c ? '0 : (tick_cnt_q + TW'(1));
                if (tick_c) begin
                    fall_tick_d = 1'b1;
                    for (int i = 0; i < int'(NUM_SLOTS); i++) begin
                        if (active_q[i]) begin
                            ypos_d[i] = ypos_q[i] + YW'(1);
                            if ((ypos_d[i] == Y_BOTTOM) && !(hit_c && (win_idx_c == IW'(i))))
                                bottom_c = 1'b1;
                        end
                    end
                    if (spawn_cnt_q == SW'(SPAWN_EVERY - 1)) begin
                        spawn_cnt_d = '0;
                        spawn_c     = 1'b1;
                    end else begin
                        spawn_cnt_d = spawn_cnt_q + SW'(1);
                    end
                end
                // Clearing the matched column overrides its fall step.
                if (hit_c) begin
                    active_d[win_idx_c] = 1'b0;
                    ypos_d[win_idx_c]   = '0;
                    letter_d[win_idx_c] = '0;
                    hit_d               = 1'b1;
                    score_d             = (score_q == 8'hFF) ? score_q : (score_q + 8'd1);
                    level_raw_c         = 32'(score_d) / SCORE_PER_LEVEL;
                    level_d             = (level_raw_c > 32'd15) ? 4'd15 : 4'(level_raw_c);
                end else if (strobe_c) begin
                    miss_d = 1'b1;
                end
                // Spawn looks at the pre-cycle mask, so a slot freed this cycle stays empty.
                if (bottom_c) begin
                    state_d     = S_OVER;
                    game_over_d = 1'b1;
                end else if (spawn_c && free_found_c) begin
                    active_d[free_idx_c] = 1'b1;
                    ypos_d[free_idx_c]   = '0;
                    letter_d[free_idx_c] = lfsr_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_signal) begin
        if (!reset_signal) begin
            state_q     <= S_IDLE;
            lfsr_q      <= LFSR_SEED;
            active_q    <= '0;
            ypos_q      <= '0;
            letter_q    <= '0;
            score_q     <= '0;
            level_q     <= '0;
            tick_cnt_q  <= '0;
            spawn_cnt_q <= '0;
            game_over_q <= 1'b0;
            hit_q       <= 1'b0;
            miss_q      <= 1'b0;
            fall_tick_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            active_q    <= active_d;
            ypos_q      <= ypos_d;
            letter_q    <= letter_d;
            score_q     <= score_d;
            level_q     <= level_d;
            tick_cnt_q  <= tick_cnt_d;
            spawn_cnt_q <= spawn_cnt_d;
            game_over_q <= game_over_d;
            hit_q       <= hit_d;
            miss_q      <= miss_d;
            fall_tick_q <= fall_tick_d;
        end
    end

    assign bus.slot_active = active_q;
    assign bus.slot_ypos   = ypos_q;
    assign bus.slot_letter = letter_q;
    assign bus.score       = score_q;
    assign bus.level       = level_q;
    assign bus.game_over   = game_over_q;
    assign bus.hit         = hit_q;
    assign bus.miss        = miss_q;
    assign bus.fall_tick   = fall_tick_q;
endmodule

// File: doc/column_scheduler.md
Name: column_scheduler

Overview:
Game controller for the falling-letter playfield. It owns a pool of column slots, generates a shared fall tick, spawns new columns with pseudo-random letters, and matches player entries against active columns. It scores hits, raises speed with score, and declares game over when any column reaches the bottom row. It sits between the switch/button input logic and the display renderer.

Parameters:
NUM_SLOTS, 4, number of simultaneously falling columns
BOTTOM_ROW, 22, row at which a column ends the game
TICK_START, 50000000, fall period in clocks at level 0
TICK_MIN, 5000000, minimum fall period
TICK_STEP, 2500000, period reduction per level
SPAWN_EVERY, 4, fall ticks between spawns
SCORE_PER_LEVEL, 8, hits per level increment

Ports:
clock  in  1  system clock; all state on rising edge
reset_signal  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse; starts or restarts a game
user_input  in  8  player's byte from switches
user_strobe  in  1  one-cycle pulse; submit user_input
slot_active  out  NUM_SLOTS  per-slot active flag
slot_ypos  out  5*NUM_SLOTS  packed rows; slot i at [5i+4:5i]
slot_letter  out  8*NUM_SLOTS  packed letters; slot i at [8i+7:8i]
score  out  8  hit count, saturates at 255
level  out  4  min(score/SCORE_PER_LEVEL, 15)
game_over  out  1  high while in OVER
hit  out  1  one-cycle pulse on a matched strobe
miss  out  1  one-cycle pulse on an unmatched strobe
fall_tick  out  1  one-cycle pulse per fall step

Behaviour:
- Reset (reset_signal=0, no clock required): state IDLE; all outputs 0; tick and spawn counters 0; LFSR = 8'hA5.
- LFSR: 8-bit Galois, polynomial x^8+x^6+x^5+x^4+1. Advances every clock in every state. Never zero.
- States: IDLE, PLAYING, OVER.
  - IDLE/OVER + start -> PLAYING.
  - PLAYING + bottom reached -> OVER.
  - start in PLAYING is ignored.
- Entering PLAYING: clear all slots, score, level, tick counter and spawn counter; on the same edge activate slot 0 with ypos 0 and letter = current LFSR.
- Period = max(TICK_START - level*TICK_STEP, TICK_MIN), computed in 26 bits with no underflow (clamp before subtract).
- Tick counter runs only in PLAYING. When count == period-1: fall_tick=1 for one cycle and the counter returns to 0.
- On fall_tick:
  - Every active slot does ypos+1.
  - If any slot's new ypos == BOTTOM_ROW: game_over=1 and state=OVER on that same edge.
  - Spawn counter increments and wraps at SPAWN_EVERY. On wrap, the lowest-index inactive slot is activated with ypos 0 and letter = LFSR.
  - No free slot -> spawn skipped; counter still wraps.
  - No spawn on the tick that causes game over.
- user_strobe in PLAYING compares user_input with every active slot's letter.
  - Match: the winner is the matching slot with the highest ypos; ties go to the lowest index. Winner is cleared (active=0, ypos=0, letter=0). hit=1 and score+1 (saturating) on the next edge.
  - No match: miss=1; nothing else changes.
  - Strobes in IDLE/OVER are ignored (no hit/miss).
- Simultaneous strobe and fall_tick:
  - Matching uses pre-tick ypos.
  - Clear wins over increment.
  - A matched slot does not trigger game over even if its increment would reach BOTTOM_ROW.
  - Spawn uses the pre-cycle active mask, so a just-freed slot is not refilled that cycle.
- level updates registered, on the same edge as score.
- OVER: slot outputs, score and level freeze; tick counter holds.
- Latency: hit/miss/slot changes are visible one clock after the strobe edge.
- Mid-game reset: immediate return to reset values.

Test Plan:
(All scenarios use TICK_START=10, TICK_MIN=4, TICK_STEP=2, SPAWN_EVERY=2, SCORE_PER_LEVEL=2.)
1. Reset, then start pulse -> slot_active=4'b0001, slot 0 letter = LFSR at start edge, ypos 0; fall_tick every 10 clocks; slot 1 spawns on tick 2.
2. Strobe with slot 0's letter -> hit=1 for one cycle, slot_active[0]=0, score=1. Strobe 8'h00 -> miss=1, score stays 1.
3. Two active slots, same letter, ypos 5 and 3 -> strobe clears only the ypos-5 slot.
4. No input -> slot 0 reaches ypos 22 on tick 22: game_over=1, fall_tick stops, strobes ignored. start -> game_over=0, fresh slot 0.
5. score reaches 2 -> level 1, period 8. score 8 -> level 4, period clamps at 4.
6. Strobe matching a slot at ypos 21 on the same cycle as fall_tick -> slot cleared, hit=1, no game_over.
